// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Control unit for a 5-stage MIPS-style pipeline. It has four
//               jobs:
//               - decode the ID-stage opcode into WB/MEM/EX control bundles;
//               - detect load-use hazards and insert a one-cycle bubble;
//               - redirect and flush the pipeline on a taken branch;
//               - sequence a halt through a short drain into a terminal
//                 HALTED state.
//               It also counts stall and flush events.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1   clock, rising-edge active
//   rst            in   1   asynchronous reset, active-low
//   instr_id       in  32   ID instruction: opcode[31:26] rs[25:21] rt[20:16]
//   ex_memread     in   1   ID/EX holds a load
//   ex_rt          in   5   rt of the ID/EX instruction
//   branch_taken   in   1   MEM-stage branch resolved taken
//   WBID           out  2   {RegWrite, MemtoReg}
//   MEID           out  3   {Branch, MemRead, MemWrite}
//   EXID           out  4   {RegDst, ALUOp1, ALUOp0, ALUSrc}
//   pc_we/ifid_we  out  1   PC and IF/ID write enables
//   pc_src         out  1   PC loads the branch target
//   flush_*        out  1   zero the control bundles of that pipeline register
//   illegal        out  1   unknown opcode in ID
//   done           out  1   pipeline drained after halt (registered)
//   stall_cnt      out 16   saturating load-use stall counter
//   flush_cnt      out 16   saturating branch flush counter
// ============================================================================
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_id,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  output logic [1:0]  WBID,
  output logic [2:0]  MEID,
  output logic [3:0]  EXID,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        pc_src,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        illegal,
  output logic        done,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0]  C_ST_RUN    = 2'd0;
  localparam logic [1:0]  C_ST_DRAIN  = 2'd1;
  localparam logic [1:0]  C_ST_HALTED = 2'd2;

  localparam logic [5:0]  C_OP_RTYPE  = 6'h00;
  localparam logic [5:0]  C_OP_LW     = 6'h23;
  localparam logic [5:0]  C_OP_SW     = 6'h2B;
  localparam logic [5:0]  C_OP_BEQ    = 6'h04;
  localparam logic [5:0]  C_OP_ADDI   = 6'h08;
  localparam logic [5:0]  C_OP_HALT   = 6'h3F;

  localparam logic [1:0]  C_DRAIN_LAST = 2'd2;
  localparam logic [15:0] C_CNT_MAX    = 16'hFFFF;

  logic [1:0]  state_q, state_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        done_q, done_d;

  logic [5:0]  opcode;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic [8:0]  dec_bundle;   // {WB[1:0], ME[2:0], EX[3:0]}
  logic        dec_known;
  logic        load_use;
  logic [8:0]  bundle;
  logic        stall_inc;
  logic        flush_inc;
  logic        unused_instr_bits;

  assign opcode = instr_id[31:26];
  assign rs_id  = instr_id[25:21];
  assign rt_id  = instr_id[20:16];

  // Immediate/funct bits carry no control information.
  assign unused_instr_bits = ^instr_id[15:0];

  // Opcode decode.
  always_comb begin
    dec_bundle = 9'b0;
    dec_known  = 1'b1;
    case (opcode)
      C_OP_RTYPE: dec_bundle = {2'b11, 3'b000, 4'b0100};
      C_OP_LW:    dec_bundle = {2'b10, 3'b010, 4'b1001};
      C_OP_SW:    dec_bundle = {2'b00, 3'b001, 4'b1001};
      C_OP_BEQ:   dec_bundle = {2'b00, 3'b100, 4'b0010};
      C_OP_ADDI:  dec_bundle = {2'b11, 3'b000, 4'b1001};
      C_OP_HALT:  dec_bundle = 9'b0;
      default:    dec_known  = 1'b0;
    endcase
  end

  // $zero is never a real dependency, so ex_rt == 0 cannot cause a hazard.
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == rs_id) || (ex_rt == rt_id));

  // Next-state and pipeline control.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    bundle      = 9'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    pc_src      = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;

    case (state_q)
      C_ST_RUN: begin
        if (branch_taken) begin
          // Branch outranks load-use: the stalled instruction is flushed anyway.
          pc_src      = 1'b1;
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
          bundle      = dec_bundle;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          stall_inc = 1'b1;
        end else if (opcode == C_OP_HALT) begin
          // Halt bundles are all-zero; freeze fetch and start draining.
          state_d     = C_ST_DRAIN;
          drain_cnt_d = 2'd0;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          bundle  = dec_bundle;
        end
      end

      C_ST_DRAIN: begin
        if (branch_taken && (drain_cnt_q == 2'd0)) begin
          // The halt was on a wrong path: redirect and resume.
          pc_src      = 1'b1;
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
          flush_inc   = 1'b1;
          state_d     = C_ST_RUN;
        end else begin
          flush_ifid  = 1'b1;
          drain_cnt_d = drain_cnt_q + 2'd1;
          if (drain_cnt_q == C_DRAIN_LAST) begin
            state_d = C_ST_HALTED;
          end
        end
      end

      C_ST_HALTED: begin
        state_d = C_ST_HALTED;
      end

      default: begin
        state_d = C_ST_RUN;
      end
    endcase

    // Keep the datapath quiet while reset is asserted.
    if (!rst) begin
      bundle      = 9'b0;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      pc_src      = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
    end
  end

  // Counter updates and done flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_inc && (flush_cnt_q != C_CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
    done_d = (state_d == C_ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= C_ST_RUN;
      drain_cnt_q <= 2'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
    end
  end

  assign WBID      = bundle[8:7];
  assign MEID      = bundle[6:4];
  assign EXID      = bundle[3:0];
  assign illegal   = ~dec_known;
  assign done      = done_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Directed scenarios and
//               a randomized phase, all compared against a cycle-level
//               reference model. The model tracks the halt sequence as an
//               "age" counter: -1 = running, 0..2 = draining, 3 = halted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_id = 32'h0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        branch_taken = 1'b0;
  logic [1:0]  WBID;
  logic [2:0]  MEID;
  logic [3:0]  EXID;
  logic        pc_we, ifid_we, pc_src;
  logic        flush_ifid, flush_idex, flush_exmem;
  logic        illegal, done;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_age   = -1;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_id     (instr_id),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .WBID         (WBID),
    .MEID         (MEID),
    .EXID         (EXID),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .pc_src       (pc_src),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .flush_exmem  (flush_exmem),
    .illegal      (illegal),
    .done         (done),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control-bundle table, {WB, ME, EX}.
  function automatic logic [9:0] ref_decode(input logic [5:0] op);
    // bit 9 = opcode is known
    case (op)
      6'h00:   return {1'b1, 9'b11_000_0100};
      6'h23:   return {1'b1, 9'b10_010_1001};
      6'h2B:   return {1'b1, 9'b00_001_1001};
      6'h04:   return {1'b1, 9'b00_100_0010};
      6'h08:   return {1'b1, 9'b11_000_1001};
      6'h3F:   return {1'b1, 9'b00_000_0000};
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'hA5C3};
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // One clock cycle: drive at the falling edge, check the combinational
  // response and the registered state, then advance the model past the
  // next rising edge.
  task automatic step(input logic [31:0] ins, input logic mr, input logic [4:0] rt, input logic br);
    logic [9:0] d;
    logic [8:0] e_bund;
    logic [2:0] e_fl;
    logic       e_pcwe, e_ifwe, e_src, hz, ctl_known;
    int         nxt;
    @(negedge clk);
    instr_id     = ins;
    ex_memread   = mr;
    ex_rt        = rt;
    branch_taken = br;
    #1;
    d  = ref_decode(ins[31:26]);
    hz = mr && (rt != 5'd0) && ((rt == ins[25:21]) || (rt == ins[20:16]));
    e_bund = 9'b0; e_fl = 3'b000; e_pcwe = 1'b0; e_ifwe = 1'b0; e_src = 1'b0;
    ctl_known = 1'b1;
    nxt = m_age;

    // Registered state as of the last edge.
    check("done", {31'b0, done}, {31'b0, (m_age == 3)});
    check("stall_cnt", {16'b0, stall_cnt}, 32'(m_stall));
    check("flush_cnt", {16'b0, flush_cnt}, 32'(m_flush));

    if (m_age < 0) begin
      if (br) begin
        e_src = 1'b1; e_fl = 3'b111; ctl_known = 1'b0;
        m_flush = sat16(m_flush + 1);
      end else if (hz) begin
        m_stall = sat16(m_stall + 1);
      end else if (ins[31:26] == 6'h3F) begin
        nxt = 0;
      end else begin
        e_pcwe = 1'b1; e_ifwe = 1'b1; e_bund = d[8:0];
      end
    end else if (m_age <= 2) begin
      if (br && m_age == 0) begin
        e_src = 1'b1; e_fl = 3'b111; ctl_known = 1'b0;
        m_flush = sat16(m_flush + 1);
        nxt = -1;
      end else begin
        e_fl = 3'b100;
        nxt = m_age + 1;
      end
    end

    check("illegal", {31'b0, illegal}, {31'b0, ~d[9]});
    check("pc_src", {31'b0, pc_src}, {31'b0, e_src});
    check("flushes", {29'b0, flush_ifid, flush_idex, flush_exmem}, {29'b0, e_fl});
    if (ctl_known) begin
      check("pc_we", {31'b0, pc_we}, {31'b0, e_pcwe});
      check("ifid_we", {31'b0, ifid_we}, {31'b0, e_ifwe});
      check("bundles", {23'b0, WBID, MEID, EXID}, {23'b0, e_bund});
    end
    m_age = nxt;
  endtask

  // Assert reset at a falling edge and check its immediate effect.
  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    instr_id     = mk(6'h00, 5'd3, 5'd3);
    ex_memread   = 1'b1;
    ex_rt        = 5'd3;
    branch_taken = 1'b1;
    #1;
    check("rst_ctl", {26'b0, pc_we, ifid_we, pc_src, flush_ifid, flush_idex, flush_exmem}, 32'h0);
    check("rst_bundles", {23'b0, WBID, MEID, EXID}, 32'h0);
    check("rst_counters", {stall_cnt, flush_cnt}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    m_age = -1; m_stall = 0; m_flush = 0;
    @(negedge clk);
    instr_id     = 32'h0;
    ex_memread   = 1'b0;
    ex_rt        = 5'd0;
    branch_taken = 1'b0;
    rst          = 1'b1;
  endtask

  initial begin
    logic [5:0] opsel [7];
    logic [5:0] op;
    opsel = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3E, 6'h15};

    do_reset();

    // Decode sweep in RUN, no hazards
    foreach (opsel[i]) step(mk(opsel[i], 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);

    // Load-use on rs, then on rt, then with ex_rt = 0 (no stall)
    step(mk(6'h00, 5'd5, 5'd7), 1'b1, 5'd5, 1'b0);
    step(mk(6'h00, 5'd5, 5'd7), 1'b0, 5'd5, 1'b0);
    step(mk(6'h2B, 5'd9, 5'd6), 1'b1, 5'd6, 1'b0);
    step(mk(6'h00, 5'd0, 5'd0), 1'b1, 5'd0, 1'b0);
    step(mk(6'h00, 5'd5, 5'd7), 1'b1, 5'd4, 1'b0);

    // Branch together with a load-use hazard
    step(mk(6'h00, 5'd5, 5'd7), 1'b1, 5'd5, 1'b1);
    step(mk(6'h08, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);

    // Halt, full drain, then a branch while halted
    step(mk(6'h3F, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);

    // Halt squashed by a branch on the next cycle
    do_reset();
    step(mk(6'h3F, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    // Branch one cycle later is ignored
    step(mk(6'h3F, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_age == 3 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 11) == 0) op = 6'h3F;
        else if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
        else op = opsel[$urandom_range(0, 5)];
        step(mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0));
      end
    end

    // Stall counter saturation
    do_reset();
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.stall_cnt_q;
    m_stall = 65534;
    for (int k = 0; k < 3; k++) step(mk(6'h00, 5'd5, 5'd7), 1'b1, 5'd7, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);

    // Reset in the middle of a drain, then resume in RUN
    step(mk(6'h3F, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    do_reset();
    step(mk(6'h23, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
    step(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-003 instr_id  in  32  instruction in ID; opcode [31:26], rs [25:21], rt [20:16].
REQ-004 ex_memread  in  1  ID/EX stage holds a load (ID/EX MEM bundle bit 1).
REQ-005 ex_rt  in  5  rt field of the ID/EX instruction.
REQ-006 branch_taken  in  1  MEM-stage branch resolved taken (Branch & zero).
REQ-007 WBID  out  2  {RegWrite, MemtoReg}; bit0 = 1 selects ALU result for write-back.
REQ-008 MEID  out  3  {Branch, MemRead, MemWrite}.
REQ-009 EXID  out  4  {RegDst, ALUOp1, ALUOp0, ALUSrc}; RegDst = 1 selects rt as destination.
REQ-010 pc_we, ifid_we  out  1 each  PC and IF/ID write enables.
REQ-011 pc_src  out  1  1 = PC loads branch target.
REQ-012 flush_ifid, flush_idex, flush_exmem  out  1 each  zero the control bundles of that pipeline register.
REQ-013 illegal  out  1  unknown opcode in ID.
REQ-014 done  out  1  pipeline drained after halt.
REQ-015 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-016 Decode SHALL be combinational from the opcode. Outputs are WBID/MEID/EXID:
- 000000 R-type: 11/000/0100
- 100011 lw: 10/010/1001
- 101011 sw: 00/001/1001
- 000100 beq: 00/100/0010
- 001000 addi: 11/000/1001
- 111111 halt: 00/000/0000
REQ-017 Any other opcode SHALL drive all bundles to 0 and set illegal = 1; illegal SHALL NOT stall.
REQ-018 FSM states SHALL be RUN, DRAIN and HALTED, plus a 2-bit drain_cnt.
REQ-019 Load-use hazard: ex_memread = 1, ex_rt != 0, and ex_rt equals rs or rt of instr_id.
REQ-020 Load-use in RUN: pc_we = 0, ifid_we = 0 and bundles zeroed (bubble) for exactly that cycle; stall_cnt +1.
REQ-021 branch_taken in RUN: pc_src = 1 and flush_ifid = flush_idex = flush_exmem = 1 in the same cycle; flush_cnt +1.
REQ-022 branch_taken SHALL have priority over load-use; stall_cnt SHALL NOT increment that cycle.
REQ-023 Halt opcode in RUN with no branch_taken: halt bundles issue, pc_we = 0, ifid_we = 0; next state DRAIN with drain_cnt = 0.
REQ-024 DRAIN: pc_we = 0, ifid_we = 0, flush_ifid = 1, bundles zeroed; drain_cnt +1 per cycle; at drain_cnt = 2 next state HALTED.
REQ-025 branch_taken in DRAIN with drain_cnt = 0 (halt squashed): pc_src = 1, all three flushes = 1, flush_cnt +1, next state RUN.
REQ-026 branch_taken in DRAIN with drain_cnt != 0 SHALL be ignored.
REQ-027 HALTED: done = 1, pc_we = 0, ifid_we = 0, bundles zeroed, flush outputs 0; HALTED is left only by reset.
REQ-028 Counters SHALL saturate at 0xFFFF; no wrap.
REQ-029 Outputs other than counters and done SHALL be combinational from state and inputs; latency 0 cycles.

Reset
REQ-030 rst = 0 SHALL immediately force state RUN, drain_cnt = 0, stall_cnt = 0, flush_cnt = 0 and done = 0, including mid-DRAIN.
REQ-031 During reset: pc_we = 0, ifid_we = 0, pc_src = 0, flushes = 0 and bundles = 0.
REQ-032 The first active edge after rst rises SHALL operate in RUN.

Verification
REQ-033 Decode sweep: opcodes 00,23,2B,04,08,3F,3E hex -> bundles per REQ-016/017; illegal = 1 only for 3E.
REQ-034 Load-use: ex_memread = 1, ex_rt = 5, instr_id rs = 5 -> one cycle with pc_we = 0 and bundles 0, stall_cnt = 1. Same with ex_rt = 0 -> no stall.
REQ-035 Branch plus load-use in the same cycle -> pc_src = 1, three flushes, flush_cnt = 1, stall_cnt unchanged.
REQ-036 Halt -> DRAIN for 3 cycles -> done = 1 on the 4th edge; branch_taken while HALTED has no effect.
REQ-037 Halt, then branch_taken the next cycle -> return to RUN, done stays 0. Same branch one cycle later -> ignored, done = 1.
REQ-038 Force stall_cnt to 0xFFFE, apply 3 load-use stalls -> stall_cnt = 0xFFFF. Assert rst mid-DRAIN -> counters 0, state RUN.
